// File: rtl/sfetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package sfetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          IF_ID_W          = 32;

    typedef struct packed {
        logic               valid;
        logic [IF_ID_W-1:0] instr;
        logic [IF_ID_W-1:0] pc;
        logic [IF_ID_W-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/sif_id_reg.sv
// Pipeline register holding one instruction and its PCs; flush beats load beats hold.
module sif_id_reg #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [WIDTH-1:0]  NOP_INSTR = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] pc_plus4_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o
);

    localparam logic [WIDTH-1:0] RESET_PC_P4 = RESET_PC + WIDTH'(4);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush_i) begin
            // PC fields are left alone on flush; only valid/instr matter downstream.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC_P4;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/sfetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and feeds decode via IF/ID.
module sfetch_unit
    import sfetch_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = DATA_WIDTH'(sfetch_pkg::NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                  id_ready_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_pc_plus4_o,
    output logic [31:0]           fetch_count_o
);

    localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] FOUR      = DATA_WIDTH'(4);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [31:0]           count_q, count_d;
    logic                  accept;
    logic                  load;
    logic                  flush;

    assign pc_plus4 = pc_q + FOUR;
    assign accept   = if_valid_o && id_ready_i;
    assign load     = (state_q == RUN) && fetch_en_i && !redirect_i &&
                      (!if_valid_o || id_ready_i);
    // Drain empties IF/ID once decode takes the last instruction while fetch is disabled.
    assign flush    = redirect_i || (accept && !fetch_en_i);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end
        if (redirect_i) begin
            pc_d = redirect_pc_i & WORD_MASK;
        end else if (load) begin
            pc_d = pc_plus4;
        end
        if (accept) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    sif_id_reg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .flush_i    (flush),
        .instr_i    (imem_instr_i),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .valid_o    (if_valid_o),
        .instr_o    (if_instr_o),
        .pc_o       (if_pc_o),
        .pc_plus4_o (if_pc_plus4_o)
    );

    assign imem_addr_o   = pc_q & WORD_MASK;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_sfetch_unit.sv
// Directed bench for sfetch_unit with a small combinational instruction memory model.
module tb_sfetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic [31:0] fetch_count_o;

    logic [31:0] mem [0:63];
    int          pass_cnt;
    int          total_cnt;

    sfetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ready_i    (id_ready_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc_plus4_o (if_pc_plus4_o),
        .fetch_count_o (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr_i = mem[imem_addr_o[7:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en_i = 1'b1; id_ready_i = 1'b1;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        step(); step();
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL rst_valid got %0b want 0", if_valid_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h13) $display("FAIL rst_instr got %h want 00000013", if_instr_o); else pass_cnt++;
        total_cnt++; if (if_pc_o !== 32'h0) $display("FAIL rst_pc got %h want 00000000", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_pc_plus4_o !== 32'h4) $display("FAIL rst_pc4 got %h want 00000004", if_pc_plus4_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'h0) $display("FAIL rst_count got %0d want 0", fetch_count_o); else pass_cnt++;
        total_cnt++; if (imem_addr_o !== 32'h0) $display("FAIL rst_addr got %h want 00000000", imem_addr_o); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        step();  // BOOT cycle: no fetch yet
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL boot_valid got %0b want 0", if_valid_o); else pass_cnt++;
        total_cnt++; if (imem_addr_o !== 32'h0) $display("FAIL boot_addr got %h want 00000000", imem_addr_o); else pass_cnt++;
        step();
        total_cnt++; if (if_valid_o !== 1'b1) $display("FAIL seq0_valid got %0b want 1", if_valid_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h00000013) $display("FAIL seq0_instr got %h want 00000013", if_instr_o); else pass_cnt++;
        total_cnt++; if (if_pc_o !== 32'h0) $display("FAIL seq0_pc got %h want 00000000", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_pc_plus4_o !== 32'h4) $display("FAIL seq0_pc4 got %h want 00000004", if_pc_plus4_o); else pass_cnt++;
        total_cnt++; if (imem_addr_o !== 32'h4) $display("FAIL seq0_addr got %h want 00000004", imem_addr_o); else pass_cnt++;
        step();
        total_cnt++; if (if_instr_o !== 32'h00100093) $display("FAIL seq1_instr got %h want 00100093", if_instr_o); else pass_cnt++;
        total_cnt++; if (if_pc_o !== 32'h4) $display("FAIL seq1_pc got %h want 00000004", if_pc_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd1) $display("FAIL seq1_count got %0d want 1", fetch_count_o); else pass_cnt++;
        step();
        total_cnt++; if (if_instr_o !== 32'h00200113) $display("FAIL seq2_instr got %h want 00200113", if_instr_o); else pass_cnt++;
        total_cnt++; if (if_pc_o !== 32'h8) $display("FAIL seq2_pc got %h want 00000008", if_pc_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd2) $display("FAIL seq2_count got %0d want 2", fetch_count_o); else pass_cnt++;
    endtask

    task automatic test_stall();
        id_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++; if (if_valid_o !== 1'b1) $display("FAIL stall_valid[%0d] got %0b want 1", i, if_valid_o); else pass_cnt++;
            total_cnt++; if (if_instr_o !== 32'h00200113) $display("FAIL stall_instr[%0d] got %h want 00200113", i, if_instr_o); else pass_cnt++;
            total_cnt++; if (if_pc_o !== 32'h8) $display("FAIL stall_pc[%0d] got %h want 00000008", i, if_pc_o); else pass_cnt++;
            total_cnt++; if (imem_addr_o !== 32'hC) $display("FAIL stall_addr[%0d] got %h want 0000000c", i, imem_addr_o); else pass_cnt++;
            total_cnt++; if (fetch_count_o !== 32'd2) $display("FAIL stall_count[%0d] got %0d want 2", i, fetch_count_o); else pass_cnt++;
        end
        id_ready_i = 1'b1;
        step();
        total_cnt++; if (if_pc_o !== 32'hC) $display("FAIL unstall_pc got %h want 0000000c", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h002081b3) $display("FAIL unstall_instr got %h want 002081b3", if_instr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd3) $display("FAIL unstall_count got %0d want 3", fetch_count_o); else pass_cnt++;
    endtask

    task automatic test_redirect();
        id_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h16;
        step();
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL redir_valid got %0b want 0", if_valid_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h13) $display("FAIL redir_instr got %h want 00000013", if_instr_o); else pass_cnt++;
        total_cnt++; if (imem_addr_o !== 32'h14) $display("FAIL redir_addr got %h want 00000014", imem_addr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd3) $display("FAIL redir_count got %0d want 3", fetch_count_o); else pass_cnt++;
        redirect_i = 1'b0; id_ready_i = 1'b1;
        step();
        total_cnt++; if (if_valid_o !== 1'b1) $display("FAIL redir_next_valid got %0b want 1", if_valid_o); else pass_cnt++;
        total_cnt++; if (if_pc_o !== 32'h14) $display("FAIL redir_next_pc got %h want 00000014", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h0041a2b3) $display("FAIL redir_next_instr got %h want 0041a2b3", if_instr_o); else pass_cnt++;
    endtask

    task automatic test_wrap();
        // Accept of pc 0x14 coincides with the redirect and must still count.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        total_cnt++; if (fetch_count_o !== 32'd4) $display("FAIL wrap_redir_count got %0d want 4", fetch_count_o); else pass_cnt++;
        total_cnt++; if (imem_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h want fffffffc", imem_addr_o); else pass_cnt++;
        redirect_i = 1'b0;
        step();
        total_cnt++; if (if_pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_pc_plus4_o !== 32'h0) $display("FAIL wrap_pc4 got %h want 00000000", if_pc_plus4_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'hC0DE_003F) $display("FAIL wrap_instr got %h want c0de003f", if_instr_o); else pass_cnt++;
        step();
        total_cnt++; if (if_pc_o !== 32'h0) $display("FAIL wrap_next_pc got %h want 00000000", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h13) $display("FAIL wrap_next_instr got %h want 00000013", if_instr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd5) $display("FAIL wrap_next_count got %0d want 5", fetch_count_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        step();
        total_cnt++; if (imem_addr_o !== 32'h20) $display("FAIL b2b_addr1 got %h want 00000020", imem_addr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd6) $display("FAIL b2b_count1 got %0d want 6", fetch_count_o); else pass_cnt++;
        redirect_pc_i = 32'h31;
        step();
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL b2b_valid got %0b want 0", if_valid_o); else pass_cnt++;
        total_cnt++; if (imem_addr_o !== 32'h30) $display("FAIL b2b_addr2 got %h want 00000030", imem_addr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd6) $display("FAIL b2b_count2 got %0d want 6", fetch_count_o); else pass_cnt++;
        redirect_i = 1'b0;
        step();
        total_cnt++; if (if_pc_o !== 32'h30) $display("FAIL b2b_pc got %h want 00000030", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'hC0DE_000C) $display("FAIL b2b_instr got %h want c0de000c", if_instr_o); else pass_cnt++;
    endtask

    task automatic test_drain();
        fetch_en_i = 1'b0;
        step();
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL drain_valid got %0b want 0", if_valid_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h13) $display("FAIL drain_instr got %h want 00000013", if_instr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd7) $display("FAIL drain_count got %0d want 7", fetch_count_o); else pass_cnt++;
        step();
        total_cnt++; if (imem_addr_o !== 32'h34) $display("FAIL drain_addr got %h want 00000034", imem_addr_o); else pass_cnt++;
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL drain_idle_valid got %0b want 0", if_valid_o); else pass_cnt++;
        fetch_en_i = 1'b1;
        step();
        total_cnt++; if (if_pc_o !== 32'h34) $display("FAIL resume_pc got %h want 00000034", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'hC0DE_000D) $display("FAIL resume_instr got %h want c0de000d", if_instr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd7) $display("FAIL resume_count got %0d want 7", fetch_count_o); else pass_cnt++;
        step();
        total_cnt++; if (if_pc_o !== 32'h38) $display("FAIL resume_next_pc got %h want 00000038", if_pc_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd8) $display("FAIL resume_next_count got %0d want 8", fetch_count_o); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #2;
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL arst_valid got %0b want 0", if_valid_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h13) $display("FAIL arst_instr got %h want 00000013", if_instr_o); else pass_cnt++;
        total_cnt++; if (if_pc_o !== 32'h0) $display("FAIL arst_pc got %h want 00000000", if_pc_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd0) $display("FAIL arst_count got %0d want 0", fetch_count_o); else pass_cnt++;
        total_cnt++; if (imem_addr_o !== 32'h0) $display("FAIL arst_addr got %h want 00000000", imem_addr_o); else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
        total_cnt++; if (if_valid_o !== 1'b0) $display("FAIL arst_boot_valid got %0b want 0", if_valid_o); else pass_cnt++;
        step();
        total_cnt++; if (if_valid_o !== 1'b1) $display("FAIL arst_first_valid got %0b want 1", if_valid_o); else pass_cnt++;
        total_cnt++; if (if_pc_o !== 32'h0) $display("FAIL arst_first_pc got %h want 00000000", if_pc_o); else pass_cnt++;
        total_cnt++; if (if_instr_o !== 32'h13) $display("FAIL arst_first_instr got %h want 00000013", if_instr_o); else pass_cnt++;
        total_cnt++; if (fetch_count_o !== 32'd0) $display("FAIL arst_first_count got %0d want 0", fetch_count_o); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h00000013;
        mem[1] = 32'h00100093;
        mem[2] = 32'h00200113;
        mem[3] = 32'h002081b3;
        mem[5] = 32'h0041a2b3;

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_drain();
        test_async_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
